frame_copy_controller: RTL and testbench

- Sequences a full-frame copy from the shadow buffer into the pixel buffer so the M68k can draw off-screen and present a tear-free frame.
- Owns the shadow-buffer read port and arbitrates pixel-buffer port A between the M68k, which has fixed priority and no wait states, and its own copy engine.
- Sits between the CPU bus decode and the dual-port buffer RAMs. Port B stays dedicated to the VGA scan-out.

---
 rtl/frame_copy_controller.sv | 151 +++++++++++++++
 tb/tb_frame_copy_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_copy_controller.sv
// frame_copy_controller
// Copies DEPTH bytes from the shadow buffer into the pixel buffer, starting on
// the first vblank rising edge after a copy request, so the CPU can draw
// off-screen and present a tear-free frame. Pixel-buffer port A is shared:
// the CPU wins whenever it asserts chipselect, and the copy engine only uses
// the port in idle cycles.
//
// Ports
//   clk_clk, reset_reset_n        clock, async active-low reset
//   cpu_*                         CPU pixel-buffer access (no wait states)
//   copy_req, vblank              copy request pulse, vertical blank level
//   busy, done, tear              status: active, last-byte pulse, sticky tear
//   shadow_*                      shadow buffer read port (1-cycle latency)
//   pix_*                         pixel buffer port A (1-cycle read latency)
module frame_copy_controller #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8192
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_chipselect,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  input  logic              copy_req,
  input  logic              vblank,
  output logic              busy,
  output logic              done,
  output logic              tear,
  output logic [ADDR_W-1:0] shadow_address,
  output logic              shadow_rden,
  input  logic [DATA_W-1:0] shadow_readdata,
  output logic [ADDR_W-1:0] pix_address,
  output logic [DATA_W-1:0] pix_writedata,
  output logic              pix_wren,
  output logic              pix_rden,
  input  logic [DATA_W-1:0] pix_readdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_LAT   = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pending_q, pending_d;
  logic              tear_q, tear_d;
  logic              vblank_q;
  logic [ADDR_W-1:0] shadow_addr_q;

  logic rise, fall, copying;
  assign rise    = vblank & ~vblank_q;
  assign fall    = ~vblank & vblank_q;
  assign copying = (state_q == S_RD) || (state_q == S_LAT) || (state_q == S_WR);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    pending_d = pending_q;
    tear_d    = tear_q;
    // A request while busy is remembered once; DONE consumes it below.
    if (busy && copy_req) pending_d = 1'b1;
    if (fall && copying)  tear_d    = 1'b1;
    case (state_q)
      S_IDLE: if (copy_req) begin
        state_d = S_ARMED;
        ptr_d   = '0;
        tear_d  = 1'b0;
      end
      S_ARMED: if (rise) state_d = S_RD;
      S_RD:    state_d = S_LAT;
      S_LAT: begin
        data_d  = shadow_readdata;
        state_d = S_WR;
      end
      S_WR: if (!cpu_chipselect) begin
        // CPU owns port A this cycle otherwise: hold the byte and retry.
        if (ptr_q == LAST) state_d = S_DONE;
        else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        // A request landing in DONE itself counts as pending too.
        if (pending_q || copy_req) begin
          state_d   = S_ARMED;
          ptr_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      data_q        <= '0;
      pending_q     <= 1'b0;
      tear_q        <= 1'b0;
      vblank_q      <= 1'b0;
      shadow_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      tear_q    <= tear_d;
      vblank_q  <= vblank;
      if (state_q == S_RD) shadow_addr_q <= ptr_q;
    end
  end

  // Shadow address is live from ptr in RD and parks on the last value after.
  assign shadow_address = (state_q == S_RD) ? ptr_q : shadow_addr_q;
  assign shadow_rden    = (state_q == S_RD);

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign tear = tear_q;

  always_comb begin
    if (cpu_chipselect) begin
      pix_address   = cpu_address;
      pix_writedata = cpu_writedata;
      pix_wren      = cpu_write;
      pix_rden      = ~cpu_write;
    end else begin
      pix_address   = ptr_q;
      pix_writedata = data_q;
      pix_wren      = (state_q == S_WR);
      pix_rden      = 1'b0;
    end
  end

  assign cpu_readdata = pix_readdata;

endmodule

// File: tb/tb_frame_copy_controller.sv
module tb_frame_copy_controller;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEP   = 3072;
  localparam int MEMSZ = 8192;
  localparam int BUDGET = 3 * DEP + 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic          cpu_chipselect = 1'b0;
  logic          cpu_write = 1'b0;
  logic [DW-1:0] cpu_writedata = '0;
  logic [DW-1:0] cpu_readdata;
  logic          copy_req = 1'b0;
  logic          vblank = 1'b0;
  logic          busy, done, tear;
  logic [AW-1:0] shadow_address;
  logic          shadow_rden;
  logic [DW-1:0] shadow_readdata;
  logic [AW-1:0] pix_address;
  logic [DW-1:0] pix_writedata;
  logic          pix_wren, pix_rden;
  logic [DW-1:0] pix_readdata;

  frame_copy_controller #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cpu_address(cpu_address), .cpu_chipselect(cpu_chipselect),
    .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .copy_req(copy_req), .vblank(vblank),
    .busy(busy), .done(done), .tear(tear),
    .shadow_address(shadow_address), .shadow_rden(shadow_rden),
    .shadow_readdata(shadow_readdata), .pix_address(pix_address),
    .pix_writedata(pix_writedata), .pix_wren(pix_wren), .pix_rden(pix_rden),
    .pix_readdata(pix_readdata)
  );

  always #5 clk = ~clk;

  // Buffer RAMs: synchronous, one cycle read latency.
  logic [DW-1:0] shadow_mem [MEMSZ];
  logic [DW-1:0] pix_mem    [MEMSZ];
  logic [DW-1:0] shadow_rd, pix_rd;
  always @(posedge clk) begin
    if (shadow_rden) shadow_rd <= shadow_mem[shadow_address];
    if (pix_wren)    pix_mem[pix_address] <= pix_writedata;
    if (pix_rden)    pix_rd <= pix_mem[pix_address];
  end
  assign shadow_readdata = shadow_rd;
  assign pix_readdata    = pix_rd;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Reference: expected pixel contents after each completed operation.
  logic [DW-1:0] exp_pix [MEMSZ];
  int n_checks = 0, n_pass = 0;
  int k, errs, d0;
  bit ok;

  task automatic fill_shadow(input bit ramp);
    for (int i = 0; i < MEMSZ; i++) shadow_mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic pulse_req();
    copy_req = 1'b1;
    @(negedge clk);
    copy_req = 1'b0;
  endtask

  // Request a copy, then raise vblank at a negedge; k counts negedges after.
  task automatic start_copy();
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    pulse_req();
    repeat (2) @(negedge clk);
    vblank = 1'b1;
    k = 0;
  endtask

  task automatic wait_wr(input logic [AW-1:0] a);
    ok = 1'b0;
    while (k < BUDGET) begin
      @(negedge clk); k++;
      if (pix_wren && !cpu_chipselect && pix_address == a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done();
    ok = 1'b0;
    while (k < BUDGET) begin
      @(negedge clk); k++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_copy_errs();
    errs = 0;
    for (int i = 0; i < DEP; i++) if (pix_mem[i] !== shadow_mem[i]) errs++;
    for (int i = 0; i < DEP; i++) exp_pix[i] = shadow_mem[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, tear, shadow_rden, pix_wren, pix_rden} !== 6'b0)
      $display("FAIL reset_flags got=%b exp=000000", {busy, done, tear, shadow_rden, pix_wren, pix_rden});
    else n_pass++;
    n_checks++;
    if (shadow_address !== '0) $display("FAIL reset_shadow_addr got=%h exp=0", shadow_address);
    else n_pass++;
    n_checks++;
    if (pix_address !== '0 || pix_writedata !== '0)
      $display("FAIL reset_pix_idle got=%h/%h exp=0/0", pix_address, pix_writedata);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy got=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_basic_copy();
    fill_shadow(1'b1);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    pulse_req();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_armed_busy got=%b exp=1", busy);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (shadow_rden !== 1'b0) $display("FAIL basic_no_start_without_rise got=%b exp=0", shadow_rden);
    else n_pass++;
    vblank = 1'b1;
    k = 0;
    @(negedge clk); k++;
    n_checks++;
    if (shadow_rden !== 1'b1 || shadow_address !== '0)
      $display("FAIL basic_first_read got rden=%b addr=%h exp rden=1 addr=0", shadow_rden, shadow_address);
    else n_pass++;
    wait_done();
    n_checks++;
    if (!ok || k != 3 * DEP + 1) $display("FAIL basic_done_latency got=%0d exp=%0d", ok ? k : -1, 3 * DEP + 1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tear !== 1'b0)
      $display("FAIL basic_after_done got done=%b busy=%b tear=%b exp 0/0/0", done, busy, tear);
    else n_pass++;
    vblank = 1'b0;
    count_copy_errs();
    n_checks++;
    if (errs != 0) $display("FAIL basic_pixels got=%0d bad bytes exp=0", errs);
    else n_pass++;
  endtask

  task automatic test_cpu_stall();
    fill_shadow(1'b0);
    start_copy();
    wait_wr(13'h0100);
    n_checks++;
    if (!ok) $display("FAIL stall_reach_wr got=timeout exp=WR@0100");
    else n_pass++;
    cpu_chipselect = 1'b1; cpu_write = 1'b1; cpu_address = 13'h0100; cpu_writedata = 8'hA5;
    #1;
    n_checks++;
    if (pix_wren !== 1'b1 || pix_rden !== 1'b0 || pix_address !== 13'h0100 || pix_writedata !== 8'hA5)
      $display("FAIL stall_cpu_owns_port got wren=%b rden=%b a=%h d=%h exp 1/0/0100/a5",
               pix_wren, pix_rden, pix_address, pix_writedata);
    else n_pass++;
    errs = 0;
    repeat (5) begin
      @(negedge clk); k++;
      if (shadow_rden !== 1'b0) errs++;
    end
    n_checks++;
    if (errs != 0 || pix_mem[13'h0100] !== 8'hA5)
      $display("FAIL stall_cpu_write got mem=%h advance=%0d exp mem=a5 advance=0", pix_mem[13'h0100], errs);
    else n_pass++;
    cpu_chipselect = 1'b0; cpu_write = 1'b0;
    #1;
    n_checks++;
    if (pix_wren !== 1'b1 || pix_address !== 13'h0100 || pix_writedata !== shadow_mem[13'h0100])
      $display("FAIL stall_deferred_write got wren=%b a=%h d=%h exp 1/0100/%h",
               pix_wren, pix_address, pix_writedata, shadow_mem[13'h0100]);
    else n_pass++;
    wait_done();
    n_checks++;
    if (!ok || k != 3 * DEP + 1 + 5) $display("FAIL stall_latency got=%0d exp=%0d", ok ? k : -1, 3 * DEP + 6);
    else n_pass++;
    vblank = 1'b0;
    @(negedge clk);
    count_copy_errs();
    n_checks++;
    if (errs != 0 || pix_mem[13'h0100] !== shadow_mem[13'h0100])
      $display("FAIL stall_pixels got=%0d bad bytes exp=0", errs);
    else n_pass++;
  endtask

  task automatic test_cpu_rw();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 13'h0010 : 13'($urandom_range(MEMSZ - 1));
      d = (n == 0) ? 8'h3C : 8'($urandom);
      cpu_chipselect = 1'b1; cpu_write = 1'b1; cpu_address = a; cpu_writedata = d;
      @(negedge clk);
      exp_pix[a] = d;
      cpu_write = 1'b0;
      #1;
      n_checks++;
      if (pix_rden !== 1'b1 || pix_wren !== 1'b0)
        $display("FAIL cpu_read_enables got rden=%b wren=%b exp 1/0", pix_rden, pix_wren);
      else n_pass++;
      @(negedge clk);
      cpu_chipselect = 1'b0;
      n_checks++;
      if (cpu_readdata !== exp_pix[a])
        $display("FAIL cpu_readdata addr=%h got=%h exp=%h", a, cpu_readdata, exp_pix[a]);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || pix_wren !== 1'b0) $display("FAIL cpu_idle got busy=%b wren=%b exp 0/0", busy, pix_wren);
    else n_pass++;
  endtask

  task automatic test_tear();
    fill_shadow(1'b0);
    start_copy();
    wait_wr(13'(1000));
    vblank = 1'b0;
    @(negedge clk); k++;
    n_checks++;
    if (!ok || tear !== 1'b1) $display("FAIL tear_set got=%b exp=1", tear);
    else n_pass++;
    wait_done();
    n_checks++;
    if (!ok || tear !== 1'b1) $display("FAIL tear_copy_completes got done=%b tear=%b exp 1/1", ok, tear);
    else n_pass++;
    @(negedge clk);
    count_copy_errs();
    n_checks++;
    if (errs != 0) $display("FAIL tear_pixels got=%0d bad bytes exp=0", errs);
    else n_pass++;
    pulse_req();
    n_checks++;
    if (tear !== 1'b0 || busy !== 1'b1) $display("FAIL tear_clear got tear=%b busy=%b exp 0/1", tear, busy);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_pending();
    fill_shadow(1'b0);
    d0 = done_cnt;
    start_copy();
    repeat (100) begin @(negedge clk); k++; end
    pulse_req(); k++;
    repeat (50) begin @(negedge clk); k++; end
    pulse_req(); k++;
    wait_done();
    n_checks++;
    if (!ok) $display("FAIL pending_first_done got=timeout exp=done");
    else n_pass++;
    // vblank is still high: the re-armed copy must wait for a fresh rise.
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (shadow_rden !== 1'b0 || busy !== 1'b1) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL pending_rearm_wait got=%0d bad cycles exp=0", errs);
    else n_pass++;
    vblank = 1'b0;
    repeat (5) @(negedge clk);
    vblank = 1'b1;
    k = 0;
    @(negedge clk); k++;
    n_checks++;
    if (shadow_rden !== 1'b1) $display("FAIL pending_second_start got=%b exp=1", shadow_rden);
    else n_pass++;
    wait_done();
    n_checks++;
    if (!ok || k != 3 * DEP + 1) $display("FAIL pending_second_latency got=%0d exp=%0d", ok ? k : -1, 3 * DEP + 1);
    else n_pass++;
    vblank = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 2 || busy !== 1'b0)
      $display("FAIL pending_done_count got=%0d busy=%b exp 2/0", done_cnt - d0, busy);
    else n_pass++;
    count_copy_errs();
    n_checks++;
    if (errs != 0) $display("FAIL pending_pixels got=%0d bad bytes exp=0", errs);
    else n_pass++;
  endtask

  task automatic test_reset_mid_copy();
    fill_shadow(1'b0);
    d0 = done_cnt;
    start_copy();
    wait_wr(13'h0800);
    n_checks++;
    if (!ok) $display("FAIL rstmid_reach got=timeout exp=WR@0800");
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, tear, shadow_rden, pix_wren} !== 5'b0 || shadow_address !== '0)
      $display("FAIL rstmid_immediate got flags=%b saddr=%h exp 00000/0",
               {busy, done, tear, shadow_rden, pix_wren}, shadow_address);
    else n_pass++;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    vblank = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done_cnt != d0) $display("FAIL rstmid_idle got busy=%b dones=%0d exp 0/0", busy, done_cnt - d0);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < DEP; i++)
      if (pix_mem[i] !== ((i < 'h800) ? shadow_mem[i] : exp_pix[i])) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL rstmid_pixels got=%0d bad bytes exp=0", errs);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_cpu_stall();
    test_cpu_rw();
    test_tear();
    test_pending();
    test_reset_mid_copy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
